// File: rtl/cpu_trace_buffer.sv
// Commit-trace capture FIFO for the pipelined MIPS core, with run-length limit and valid/ready drain.
// Optional per-entry cycle timestamp (rd_stamp) when TRACE_TIMESTAMP_EN is defined.
module cpu_trace_buffer #(
  parameter int DEPTH      = 16,
  parameter int MAX_CYCLES = 4000,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             commit_valid,
  input  logic [31:0]      commit_pc,
  input  logic [31:0]      commit_instr,
  input  logic             commit_wen,
  input  logic [4:0]       commit_waddr,
  input  logic [31:0]      commit_wdata,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [31:0]      rd_pc,
  output logic [31:0]      rd_instr,
  output logic             rd_wen,
  output logic [4:0]       rd_waddr,
  output logic [31:0]      rd_wdata,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] drop_count
`ifdef TRACE_TIMESTAMP_EN
  ,
  output logic [CNT_W-1:0] rd_stamp
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  logic [31:0] pc_mem_q    [DEPTH];
  logic [31:0] instr_mem_q [DEPTH];
  logic        wen_mem_q   [DEPTH];
  logic [4:0]  waddr_mem_q [DEPTH];
  logic [31:0] wdata_mem_q [DEPTH];
`ifdef TRACE_TIMESTAMP_EN
  logic [CNT_W-1:0] stamp_mem_q [DEPTH];
`endif

  logic          empty, full, pop, capture, push, drop, limit_hit;
  logic [AW-1:0] rd_idx;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_idx    = rd_ptr_q[AW-1:0];
  assign pop       = !empty && rd_ready;
  assign capture   = (state_q == RUN) && commit_valid;
  assign push      = capture && (!full || pop);
  assign drop      = capture && !push;
  assign limit_hit = (MAX_CYCLES != 0) && (cycle_count_q == LIMIT);

  always_comb begin
    state_d       = state_q;
    overflow_d    = overflow_q;
    cycle_count_d = cycle_count_q;
    drop_count_d  = drop_count_q;
    wr_ptr_d      = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d      = rd_ptr_q + (AW+1)'(pop);
    case (state_q)
      RUN: begin
        cycle_count_d = cycle_count_q + CNT_W'(1);
        if (drop) begin
          overflow_d = 1'b1;
          if (drop_count_q != '1) drop_count_d = drop_count_q + CNT_W'(1);
        end
        if (stop || limit_hit) state_d = DONE;
      end
      default: begin
        if (start) begin
          state_d       = RUN;
          overflow_d    = 1'b0;
          cycle_count_d = '0;
          drop_count_d  = '0;
          wr_ptr_d      = '0;
          rd_ptr_d      = '0;
        end
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
      cycle_count_q <= '0;
      drop_count_q  <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      overflow_q    <= overflow_d;
      cycle_count_q <= cycle_count_d;
      drop_count_q  <= drop_count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Entry storage needs no reset; it is only observed through rd_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q[AW-1:0]]    <= commit_pc;
      instr_mem_q[wr_ptr_q[AW-1:0]] <= commit_instr;
      wen_mem_q[wr_ptr_q[AW-1:0]]   <= commit_wen;
      waddr_mem_q[wr_ptr_q[AW-1:0]] <= commit_waddr;
      wdata_mem_q[wr_ptr_q[AW-1:0]] <= commit_wdata;
`ifdef TRACE_TIMESTAMP_EN
      stamp_mem_q[wr_ptr_q[AW-1:0]] <= cycle_count_q;
`endif
    end
  end

  assign rd_valid    = !empty;
  assign rd_pc       = rd_valid ? pc_mem_q[rd_idx]    : '0;
  assign rd_instr    = rd_valid ? instr_mem_q[rd_idx] : '0;
  assign rd_wen      = rd_valid ? wen_mem_q[rd_idx]   : 1'b0;
  assign rd_waddr    = rd_valid ? waddr_mem_q[rd_idx] : '0;
  assign rd_wdata    = (rd_valid && wen_mem_q[rd_idx]) ? wdata_mem_q[rd_idx] : '0;
`ifdef TRACE_TIMESTAMP_EN
  assign rd_stamp    = rd_valid ? stamp_mem_q[rd_idx] : '0;
`endif
  assign busy        = busy_q;
  assign done        = done_q;
  assign overflow    = overflow_q;
  assign cycle_count = cycle_count_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Randomized and directed bench for cpu_trace_buffer against a queue-based reference model.
// A second small instance (no cycle limit, 4-bit counters) exercises counter wrap and drop saturation.
module tb_cpu_trace_buffer;
  localparam int DEPTH      = 16;
  localparam int MAX_CYCLES = 4000;
  localparam int CNT_W      = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, stop, commit_valid, commit_wen, rd_ready, rd_ready_w;
  logic [31:0] commit_pc, commit_instr, commit_wdata;
  logic [4:0]  commit_waddr;

  logic             rd_valid, rd_wen, busy, done, overflow;
  logic [31:0]      rd_pc, rd_instr, rd_wdata;
  logic [4:0]       rd_waddr;
  logic [CNT_W-1:0] cycle_count, drop_count;

  logic        rd_valid_w, rd_wen_w, busy_w, done_w, overflow_w;
  logic [31:0] rd_pc_w, rd_instr_w, rd_wdata_w;
  logic [4:0]  rd_waddr_w;
  logic [3:0]  cycle_count_w, drop_count_w;
`ifdef TRACE_TIMESTAMP_EN
  logic [CNT_W-1:0] rd_stamp;
  logic [3:0]       rd_stamp_w;
`endif

  cpu_trace_buffer #(.DEPTH(DEPTH), .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
    .commit_wen(commit_wen), .commit_waddr(commit_waddr), .commit_wdata(commit_wdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_instr(rd_instr),
    .rd_wen(rd_wen), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
    .busy(busy), .done(done), .overflow(overflow),
    .cycle_count(cycle_count), .drop_count(drop_count)
`ifdef TRACE_TIMESTAMP_EN
    , .rd_stamp(rd_stamp)
`endif
  );

  cpu_trace_buffer #(.DEPTH(4), .MAX_CYCLES(0), .CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
    .commit_wen(commit_wen), .commit_waddr(commit_waddr), .commit_wdata(commit_wdata),
    .rd_valid(rd_valid_w), .rd_ready(rd_ready_w), .rd_pc(rd_pc_w), .rd_instr(rd_instr_w),
    .rd_wen(rd_wen_w), .rd_waddr(rd_waddr_w), .rd_wdata(rd_wdata_w),
    .busy(busy_w), .done(done_w), .overflow(overflow_w),
    .cycle_count(cycle_count_w), .drop_count(drop_count_w)
`ifdef TRACE_TIMESTAMP_EN
    , .rd_stamp(rd_stamp_w)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    int          stamp;
  } ent_t;

  ent_t m_q[$];
  int   m_state;
  int   m_cycles, m_drops;
  bit   m_ovf;
  int   checks = 0, failures = 0;

  // Reference model: 0 = idle, 1 = capturing, 2 = finished; the trace is a plain queue.
  task automatic model_update();
    bit   pop_m;
    int   old;
    ent_t e;
    if (!reset) begin
      m_state = 0; m_q.delete(); m_cycles = 0; m_drops = 0; m_ovf = 0;
      return;
    end
    pop_m = (m_q.size() > 0) && rd_ready;
    if (m_state == 1) begin
      old = m_cycles;
      if (pop_m) void'(m_q.pop_front());
      if (commit_valid) begin
        e.pc = commit_pc; e.instr = commit_instr; e.wen = commit_wen;
        e.waddr = commit_waddr; e.wdata = commit_wdata; e.stamp = old;
        if (m_q.size() < DEPTH) m_q.push_back(e);
        else begin
          m_ovf = 1;
          if (m_drops < (1 << CNT_W) - 1) m_drops++;
        end
      end
      m_cycles = (m_cycles + 1) % (1 << CNT_W);
      if (stop || (MAX_CYCLES != 0 && old == MAX_CYCLES - 1)) m_state = 2;
    end else if (start) begin
      m_state = 1; m_q.delete(); m_cycles = 0; m_drops = 0; m_ovf = 0;
    end else if (pop_m) begin
      void'(m_q.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; commit_valid = 0; commit_pc = '0; commit_instr = '0;
    commit_wen = 0; commit_waddr = '0; commit_wdata = '0; rd_ready = 0;
  endtask

  task automatic begin_run();
    idle_inputs();
    stop = 1; step(); stop = 0;
    start = 1; step(); start = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rd_ready_w = 0;
    reset = 0; step(); step(); reset = 1; step();
    begin_run();
    for (int i = 0; i < 3; i++) begin
      commit_valid = 1; commit_pc = $urandom; commit_instr = $urandom; commit_wen = 1;
      step();
    end
    commit_valid = 0;
    checks++; if (rd_valid !== 1'b1) begin failures++; $display("[TB] FAIL reset_prefill_valid got=%0b exp=1", rd_valid); end
    reset = 0; step(); step(); reset = 1;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_valid got=%0b exp=0", rd_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%0b exp=0", done); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got=%0b exp=0", overflow); end
    checks++; if (cycle_count !== '0) begin failures++; $display("[TB] FAIL reset_cycle_count got=%0d exp=0", cycle_count); end
    checks++; if (drop_count !== '0) begin failures++; $display("[TB] FAIL reset_drop_count got=%0d exp=0", drop_count); end
    checks++; if (rd_pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_rd_pc got=%0h exp=0", rd_pc); end
  endtask

  task automatic test_single();
    begin_run();
    commit_valid = 1; commit_pc = 32'h0040_0004; commit_instr = 32'h2008_0005;
    commit_wen = 1; commit_waddr = 5'd8; commit_wdata = 32'd5;
    step();
    commit_valid = 0;
    checks++; if (rd_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_valid got=%0b exp=1", rd_valid); end
    checks++; if (rd_pc !== 32'h0040_0004) begin failures++; $display("[TB] FAIL single_pc got=%0h exp=400004", rd_pc); end
    checks++; if (rd_instr !== 32'h2008_0005) begin failures++; $display("[TB] FAIL single_instr got=%0h exp=20080005", rd_instr); end
    checks++; if (rd_wen !== 1'b1) begin failures++; $display("[TB] FAIL single_wen got=%0b exp=1", rd_wen); end
    checks++; if (rd_waddr !== 5'd8) begin failures++; $display("[TB] FAIL single_waddr got=%0d exp=8", rd_waddr); end
    checks++; if (rd_wdata !== 32'd5) begin failures++; $display("[TB] FAIL single_wdata got=%0d exp=5", rd_wdata); end
    step();
    checks++; if (rd_pc !== 32'h0040_0004) begin failures++; $display("[TB] FAIL single_hold_pc got=%0h exp=400004", rd_pc); end
    rd_ready = 1; step(); rd_ready = 0;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_drained got=%0b exp=0", rd_valid); end
    commit_valid = 1; commit_wen = 0; commit_wdata = 32'hdead_beef; step(); commit_valid = 0;
    checks++; if (rd_wdata !== 32'h0) begin failures++; $display("[TB] FAIL single_wdata_masked got=%0h exp=0", rd_wdata); end
  endtask

  task automatic test_overflow();
    begin_run();
    for (int i = 0; i < 20; i++) begin
      commit_valid = 1; commit_pc = 32'h1000 + 32'(4 * i); commit_wen = 0;
      step();
    end
    commit_valid = 0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag got=%0b exp=1", overflow); end
    checks++; if (drop_count !== 16'd4) begin failures++; $display("[TB] FAIL ovf_drops got=%0d exp=4", drop_count); end
    rd_ready = 1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_pc !== 32'h1000 + 32'(4 * i)) begin
        failures++; $display("[TB] FAIL ovf_drain_%0d got=%0h/%0b exp=%0h/1", i, rd_pc, rd_valid, 32'h1000 + 32'(4 * i));
      end
      step();
    end
    rd_ready = 0;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL ovf_empty got=%0b exp=0", rd_valid); end
  endtask

  task automatic test_full_pushpop();
    begin_run();
    for (int i = 0; i < 26; i++) begin
      commit_valid = 1; commit_pc = 32'h2000 + 32'(4 * i);
      rd_ready = (i >= 16);
      step();
    end
    commit_valid = 0; rd_ready = 0;
    checks++; if (drop_count !== '0 || overflow !== 1'b0) begin failures++; $display("[TB] FAIL pushpop_nodrop got=%0d/%0b exp=0/0", drop_count, overflow); end
    rd_ready = 1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_pc !== 32'h2000 + 32'(4 * (10 + i))) begin
        failures++; $display("[TB] FAIL pushpop_drain_%0d got=%0h/%0b exp=%0h/1", i, rd_pc, rd_valid, 32'h2000 + 32'(4 * (10 + i)));
      end
      step();
    end
    rd_ready = 0;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL pushpop_occupancy got=%0b exp=0", rd_valid); end
  endtask

  task automatic test_stop_priority();
    begin_run();
    for (int i = 0; i < 7; i++) step();
    commit_valid = 1; commit_pc = 32'hcafe_0007; step(); commit_valid = 0;
    start = 1; stop = 1; step(); start = 0; stop = 0;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL stop_wins got=done%0b/busy%0b exp=1/0", done, busy); end
    checks++; if (cycle_count !== 16'd9) begin failures++; $display("[TB] FAIL stop_cycles got=%0d exp=9", cycle_count); end
    checks++; if (rd_pc !== 32'hcafe_0007) begin failures++; $display("[TB] FAIL stop_entry got=%0h exp=cafe0007", rd_pc); end
`ifdef TRACE_TIMESTAMP_EN
    checks++; if (rd_stamp !== 16'd7) begin failures++; $display("[TB] FAIL stamp got=%0d exp=7", rd_stamp); end
`endif
    step();
    checks++; if (cycle_count !== 16'd9) begin failures++; $display("[TB] FAIL done_hold got=%0d exp=9", cycle_count); end
  endtask

  task automatic test_wrap();
    begin_run();
    for (int i = 0; i < 20; i++) begin
      commit_valid = 1; commit_pc = 32'(i); step();
    end
    commit_valid = 0;
    checks++; if (cycle_count_w !== 4'(20 % 16)) begin failures++; $display("[TB] FAIL wrap_cycles got=%0d exp=%0d", cycle_count_w, 20 % 16); end
    checks++; if (drop_count_w !== 4'd15) begin failures++; $display("[TB] FAIL drop_saturate got=%0d exp=15", drop_count_w); end
    checks++; if (busy_w !== 1'b1 || overflow_w !== 1'b1) begin failures++; $display("[TB] FAIL wrap_flags got=%0b/%0b exp=1/1", busy_w, overflow_w); end
  endtask

  task automatic test_cycle_limit();
    int n;
    begin_run();
    n = 0;
    while (!done && n < 5000) begin
      commit_valid = 1; commit_pc = 32'(n); rd_ready = 1;
      step(); n++;
    end
    checks++; if (n !== 4000) begin failures++; $display("[TB] FAIL limit_cycles_to_done got=%0d exp=4000", n); end
    checks++; if (cycle_count !== 16'd4000) begin failures++; $display("[TB] FAIL limit_count got=%0d exp=4000", cycle_count); end
    rd_ready = 0;
    for (int i = 0; i < 5; i++) begin commit_pc = 32'hffff_0000 + 32'(i); step(); end
    commit_valid = 0;
    checks++; if (rd_valid !== 1'b1 || rd_pc !== 32'd3999) begin failures++; $display("[TB] FAIL limit_last_entry got=%0h/%0b exp=f9f/1", rd_pc, rd_valid); end
    rd_ready = 1; step(); rd_ready = 0;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL limit_ignored_after_done got=%0b exp=0", rd_valid); end
  endtask

  task automatic test_random();
    logic exp_valid;
    begin_run();
    for (int i = 0; i < 400; i++) begin
      commit_valid = ($urandom_range(0, 3) != 0);
      commit_pc = $urandom; commit_instr = $urandom; commit_wen = 1'($urandom_range(0, 1));
      commit_waddr = 5'($urandom_range(0, 31)); commit_wdata = $urandom;
      rd_ready = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      stop = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 29) == 0);
      step();
      exp_valid = (m_q.size() > 0);
      checks++; if (rd_valid !== exp_valid) begin failures++; $display("[TB] FAIL rnd_valid@%0d got=%0b exp=%0b", i, rd_valid, exp_valid); end
      if (exp_valid) begin
        checks++;
        if (rd_pc !== m_q[0].pc || rd_instr !== m_q[0].instr || rd_wen !== m_q[0].wen ||
            rd_waddr !== m_q[0].waddr || rd_wdata !== (m_q[0].wen ? m_q[0].wdata : 32'h0)) begin
          failures++;
          $display("[TB] FAIL rnd_head@%0d got=%0h %0h %0b %0d %0h exp=%0h %0h %0b %0d %0h", i, rd_pc, rd_instr, rd_wen, rd_waddr, rd_wdata,
                   m_q[0].pc, m_q[0].instr, m_q[0].wen, m_q[0].waddr, m_q[0].wen ? m_q[0].wdata : 32'h0);
        end
`ifdef TRACE_TIMESTAMP_EN
        checks++; if (rd_stamp !== 16'(m_q[0].stamp)) begin failures++; $display("[TB] FAIL rnd_stamp@%0d got=%0d exp=%0d", i, rd_stamp, m_q[0].stamp); end
`endif
      end
      checks++;
      if (busy !== (m_state == 1) || done !== (m_state == 2) || overflow !== m_ovf ||
          cycle_count !== 16'(m_cycles) || drop_count !== 16'(m_drops)) begin
        failures++;
        $display("[TB] FAIL rnd_status@%0d got=%0b %0b %0b %0d %0d exp=%0b %0b %0b %0d %0d", i, busy, done, overflow, cycle_count, drop_count,
                 m_state == 1, m_state == 2, m_ovf, m_cycles, m_drops);
      end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 0;
    test_reset();
    test_single();
    test_overflow();
    test_full_pushpop();
    test_stop_priority();
    test_wrap();
    test_cycle_limit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
